// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared constants and types for the HI/LO multiply/divide unit.
package hilo_muldiv_unit_pkg;

    localparam int MD_OP_WD  = 8;
    localparam int DIV_STEPS = 32;

    localparam int OP_MULT  = 0;
    localparam int OP_MULTU = 1;
    localparam int OP_DIV   = 2;
    localparam int OP_DIVU  = 3;
    localparam int OP_MFHI  = 4;
    localparam int OP_MFLO  = 5;
    localparam int OP_MTHI  = 6;
    localparam int OP_MTLO  = 7;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_FIX  = 2'd2
    } div_state_e;

    function automatic logic [31:0] cond_neg(input logic [31:0] x, input logic neg);
        return neg ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_div.sv
// Radix-2 restoring divider core: unsigned magnitudes in, quotient and remainder out.
module div_iter_core
    import hilo_muldiv_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cancel,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quot,
    output logic [31:0] rem
);

    logic [32:0] prem_q, prem_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        run_q, run_d;
    logic [32:0] shifted;
    logic [33:0] trial;
    logic        fits;

    always_comb begin
        shifted = {prem_q[31:0], quot_q[31]};
        trial   = {1'b0, shifted} - {2'b00, dvsr_q};
        // prem_q[32] can only be set if a previous step overflowed, which restoring never does
        fits    = ~trial[33] | prem_q[32];
        done    = run_q && (cnt_q == 5'(DIV_STEPS - 1));
        prem_d  = prem_q;
        quot_d  = quot_q;
        dvsr_d  = dvsr_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        if (cancel) begin
            run_d = 1'b0;
            cnt_d = 5'd0;
        end else if (start) begin
            prem_d = 33'd0;
            quot_d = dividend;
            dvsr_d = divisor;
            cnt_d  = 5'd0;
            run_d  = 1'b1;
        end else if (run_q) begin
            prem_d = fits ? trial[32:0] : shifted;
            quot_d = {quot_q[30:0], fits};
            cnt_d  = cnt_q + 5'd1;
            if (done) run_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prem_q <= 33'd0;
            quot_q <= 32'd0;
            dvsr_q <= 32'd0;
            cnt_q  <= 5'd0;
            run_q  <= 1'b0;
        end else begin
            prem_q <= prem_d;
            quot_q <= quot_d;
            dvsr_q <= dvsr_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
        end
    end

    assign quot = quot_q;
    assign rem  = prem_q[31:0];

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit: single-cycle multiply, iterative divide, HI/LO registers.
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                md_valid,
    input  logic [MD_OP_WD-1:0] md_op,
    input  logic [31:0]         md_src1,
    input  logic [31:0]         md_src2,
    input  logic                md_cancel,
    output logic                md_ready_go,
    output logic [31:0]         md_rdata,
    output logic                md_busy
);

    div_state_e  state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        busy_q;

    logic        act;
    logic        div_op;
    logic        div_go;
    logic        s1, s2;
    logic        core_cancel;
    logic        core_done;
    logic [31:0] core_quot, core_rem;
    logic [32:0] mul_a, mul_b;
    logic [63:0] prod;
    logic        fix_ok;

    assign act    = md_valid & ~md_cancel;
    assign div_op = md_op[OP_DIV] | md_op[OP_DIVU];
    assign div_go = act & div_op & (state_q == DIV_IDLE);
    assign s1     = md_op[OP_DIV] & md_src1[31];
    assign s2     = md_op[OP_DIV] & md_src2[31];

    assign core_cancel = md_cancel & (state_q != DIV_IDLE);

    div_iter_core u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_go),
        .cancel   (core_cancel),
        .dividend (cond_neg(md_src1, s1)),
        .divisor  (cond_neg(md_src2, s2)),
        .done     (core_done),
        .quot     (core_quot),
        .rem      (core_rem)
    );

    assign mul_a = {md_op[OP_MULT] & md_src1[31], md_src1};
    assign mul_b = {md_op[OP_MULT] & md_src2[31], md_src2};
    assign prod  = 64'($signed(mul_a)) * 64'($signed(mul_b));

    assign fix_ok = (state_q == DIV_FIX) & ~md_cancel;

    always_comb begin
        state_d = state_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        unique case (state_q)
            DIV_IDLE: begin
                if (div_go) begin
                    state_d = DIV_RUN;
                    // divide-by-zero keeps the all-ones quotient unsigned
                    qneg_d  = (s1 ^ s2) & (md_src2 != 32'd0);
                    rneg_d  = s1;
                end
            end
            DIV_RUN: begin
                if (md_cancel)      state_d = DIV_IDLE;
                else if (core_done) state_d = DIV_FIX;
            end
            DIV_FIX:  state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (fix_ok) begin
            lo_d = cond_neg(core_quot, qneg_q);
            hi_d = cond_neg(core_rem, rneg_q);
        end else if (act & (md_op[OP_MULT] | md_op[OP_MULTU])) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
        end else if (act & md_op[OP_MTHI]) begin
            hi_d = md_src1;
        end else if (act & md_op[OP_MTLO]) begin
            lo_d = md_src1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= DIV_IDLE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            busy_q  <= (state_d != DIV_IDLE);
        end
    end

    always_comb begin
        md_rdata = 32'd0;
        if (md_op[OP_MFHI])      md_rdata = hi_q;
        else if (md_op[OP_MFLO]) md_rdata = lo_q;
    end

    assign md_ready_go = ~(md_valid & div_op) | (state_q == DIV_FIX) | md_cancel;
    assign md_busy     = busy_q;

endmodule
